// File: rtl/mac_pkg.sv
// mac_pkg: shared widths, accumulator rails, FSM state type and saturating add for mac_sequencer
package mac_pkg;
  localparam int MAC_DW = 32;
  localparam int ACC_W = 2 * MAC_DW;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic sat;
    logic signed [ACC_W-1:0] sum;
  } sat_res_t;
  // the two top bits of the one-bit-wider sum disagree exactly on overflow; the MSB gives its direction
  function automatic sat_res_t sat_add(input logic signed [ACC_W-1:0] x, input logic signed [ACC_W-1:0] y);
    logic [ACC_W:0] s;
    s = {x[ACC_W-1], x} + {y[ACC_W-1], y};
    sat_add.sat = s[ACC_W] ^ s[ACC_W-1];
    sat_add.sum = sat_add.sat ? (s[ACC_W] ? ACC_MIN : ACC_MAX) : s[ACC_W-1:0];
  endfunction
endpackage

// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if: operand/result handshake bundle; master = operand source/result consumer, slave = sequencer
// start/len job command, a_valid/a_ready/a/b operand stream, res_valid/res_ready/res/sat result, busy status
interface mac_sequencer_if #(parameter int DW = 32, parameter int LEN_W = 16);
  logic start;
  logic [LEN_W-1:0] len;
  logic a_valid, a_ready;
  logic signed [DW-1:0] a, b;
  logic res_valid, res_ready;
  logic signed [2*DW-1:0] res;
  logic sat, busy;
  modport master (output start, len, a_valid, a, b, res_ready, input a_ready, res_valid, res, sat, busy);
  modport slave (input start, len, a_valid, a, b, res_ready, output a_ready, res_valid, res, sat, busy);
endinterface

// File: rtl/mac_mult.sv
// mac_mult: registered signed DW x DW multiplier with one-cycle valid pipeline
// clk, n_rst (async active-low), in_valid/a/b operands in, out_valid/p full-width product out
module mac_mult #(parameter int DW = 32) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   in_valid,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic                   out_valid,
  output logic signed [2*DW-1:0] p
);
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      out_valid <= 1'b0;
      p <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) p <= a * b;
    end
endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer: length-bounded signed multiply-accumulate job with 2*DW saturating accumulator
// clk, n_rst (async active-low), bus (mac_sequencer_if.slave): start/len command, a/b operand handshake,
// res/sat result handshake, busy. Define MAC_STICKY_SAT_EN to freeze the accumulator after its first clamp.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int DW = MAC_DW,
  parameter int LEN_W = 16
) (
  input logic clk,
  input logic n_rst,
  mac_sequencer_if.slave bus
);
  state_t state, state_nx;
  logic [LEN_W-1:0] cnt;
  logic signed [2*DW-1:0] acc, prod;
  logic sat_q, pv, xfer, hold;
  sat_res_t nxt;
  mac_mult #(.DW(DW)) u_mult (
    .clk(clk), .n_rst(n_rst), .in_valid(xfer), .a(bus.a), .b(bus.b), .out_valid(pv), .p(prod)
  );
  assign xfer = bus.a_valid && state == RUN;
  assign nxt = sat_add(acc, prod);
`ifdef MAC_STICKY_SAT_EN
  assign hold = sat_q;
`else
  assign hold = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = !bus.start ? IDLE : (bus.len != '0 ? RUN : DONE);
      RUN:   state_nx = (xfer && cnt == LEN_W'(1)) ? DRAIN : RUN;
      DRAIN: state_nx = DONE;
      DONE:  state_nx = bus.res_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      sat_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.start) begin
        cnt <= bus.len;
        acc <= '0;
        sat_q <= 1'b0;
      end else begin
        if (xfer) cnt <= cnt - 1'b1;
        if (pv && !hold) begin
          acc <= nxt.sum;
          sat_q <= sat_q | nxt.sat;
        end
      end
    end
  assign bus.a_ready = state == RUN;
  assign bus.res_valid = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.res = acc;
  assign bus.sat = sat_q;
endmodule
